maint_scheduler: RTL and testbench
==================================

MAINT_SCHEDULER -- requirements
Module: maint_scheduler

Interface
REQ-001 SHALL have parameter REF_INTERVAL, default 7800: clk cycles between refresh events.
REQ-002 SHALL have parameter ZQ_INTERVAL, default 128000: clk cycles between ZQ-calibration events.
REQ-003 SHALL have parameter RD_INTERVAL, default 1000000: clk cycles between periodic-read events.
REQ-004 SHALL have parameter MAX_REF_PENDING, default 8: refresh postponement limit, range 1..15.
REQ-005 SHALL use one clock and an asynchronous, active-high reset, as listed below.
REQ-006 clk  in  1  sole clock.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 init_calib_complete  in  1  DRAM calibration done.
REQ-009 aref_en  in  1  auto-refresh enable value.
REQ-010 aref_en_valid  in  1  one-cycle strobe; loads aref_en.
REQ-011 program_active  in  1  user program executing; defers non-urgent work.
REQ-012 maint_req  out  1  maintenance request to the frontend.
REQ-013 maint_ack  in  1  frontend accepts the request.
REQ-014 maint_type  out  2  request type: 0=REF, 1=ZQ, 2=RD.
REQ-015 maint_done  in  1  one-cycle pulse; maintenance sequence finished.
REQ-016 ref_pending  out  4  count of owed refreshes.
REQ-017 urgent  out  1  high when ref_pending==MAX_REF_PENDING.
REQ-018 overflow_err  out  1  sticky; a refresh was lost.

Function
REQ-019 SHALL run three interval timers only while init_calib_complete=1; each timer wraps at INTERVAL-1 and emits a one-cycle wrap pulse.
REQ-020 Refresh timer SHALL run only while the internal enable is 1; its wrap SHALL increment ref_pending, saturating at MAX_REF_PENDING.
REQ-021 A refresh wrap while ref_pending is saturated SHALL set overflow_err, which clears only on rst.
REQ-022 ZQ and RD wraps SHALL set the single-bit flags zq_pending and rd_pending.
REQ-023 An aref_en_valid strobe SHALL load the internal enable one cycle later. Loading 0 SHALL clear ref_pending and the refresh timer.
REQ-024 While init_calib_complete=0, all timers, ref_pending and flags SHALL be held at 0. An FSM in REQ SHALL return to IDLE; an FSM in WAIT_DONE SHALL complete normally.
REQ-025 FSM states SHALL be IDLE, REQ and WAIT_DONE.
REQ-026 In IDLE with urgent=1, the FSM SHALL select REF and enter REQ regardless of program_active.
REQ-027 In IDLE with urgent=0 and program_active=0, the FSM SHALL select by priority REF (ref_pending>0) > ZQ > RD and enter REQ. With nothing pending it SHALL stay in IDLE.
REQ-028 maint_req and maint_type SHALL be registered; maint_req is high exactly while in REQ, with maint_type stable. Latency from IDLE decision to maint_req high SHALL be 1 cycle.
REQ-029 REQ SHALL go to WAIT_DONE on maint_ack; maint_req SHALL drop the following cycle. maint_ack outside REQ and maint_done outside WAIT_DONE SHALL be ignored.
REQ-030 WAIT_DONE SHALL go to IDLE on maint_done, retiring the served type: decrement ref_pending, or clear the ZQ/RD flag.
REQ-031 A same-cycle refresh wrap and REF retire SHALL leave ref_pending unchanged.
REQ-032 A same-cycle flag set and flag retire SHALL leave the flag set.
REQ-033 After a retire, IDLE SHALL wait at least 1 cycle before issuing a new request.

Reset
REQ-034 On rst, outputs SHALL be: maint_req=0, maint_type=0, ref_pending=0, urgent=0, overflow_err=0. The FSM SHALL be in IDLE, timers and flags at 0, and the internal enable at 1.
REQ-035 rst asserted mid-handshake SHALL abandon the request immediately; no retire occurs.

Structure
REQ-036 Package maint_sched_pkg SHALL hold the maint_type encodings (REF/ZQ/RD) and the FSM state encoding.
REQ-037 Sub-module maint_interval_timer SHALL implement a parameterised counter with enable, clear and wrap pulse. It is instantiated three times.

Verification (REF_INTERVAL=16, ZQ_INTERVAL=64, RD_INTERVAL=128, MAX_REF_PENDING=4)
REQ-038 Calib=1, program_active=0, ack and done immediate -> REF request every 16 cycles; ref_pending never exceeds 1.
REQ-039 program_active=1 for 80 cycles -> ref_pending reaches 4, urgent=1, and REF is issued despite program_active. ZQ stays deferred until program_active=0.
REQ-040 ack withheld for 100 cycles -> ref_pending stays 4, overflow_err=1 after the next wrap, and maint_req held with type 0.
REQ-041 aref_en_valid with aref_en=0 while ref_pending=3 -> ref_pending=0 and no REF requests afterwards; ZQ and RD still issued.
REQ-042 init_calib_complete dropped during REQ -> maint_req=0 next cycle and counters=0. rst pulsed in WAIT_DONE -> all outputs return to reset values.

Source files
------------

// File: rtl/maint_sched_pkg.sv
// Shared encodings for the DRAM maintenance scheduler: request types
// presented to the frontend and the scheduler FSM state codes.
package maint_sched_pkg;

    // Request type encodings on maint_type
    localparam logic [1:0] TYPE_REF = 2'd0;
    localparam logic [1:0] TYPE_ZQ  = 2'd1;
    localparam logic [1:0] TYPE_RD  = 2'd2;

    // Scheduler FSM state encodings
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_REQ       = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    // Width of the owed-refresh counter (holds up to 15)
    localparam int PENDING_W = 4;

endpackage

// File: rtl/maint_interval_timer.sv
// Free-running interval counter: counts 0..INTERVAL-1 while enabled and
// raises wrap for the one cycle in which it rolls over to zero.
// clr has priority over en and suppresses the wrap pulse.
module maint_interval_timer #(
    parameter int INTERVAL = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int              CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(INTERVAL - 1);

    logic [CNT_W-1:0] count;

    // Interval counter: cleared on clr, advances and rolls over while enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end else begin
            count <= count;
        end
    end

    assign wrap = en & ~clr & (count == LAST);

endmodule

// File: rtl/maint_scheduler.sv
// DRAM maintenance scheduler. Three interval timers generate refresh,
// ZQ-calibration and periodic-read events; owed work is tracked and handed
// to the frontend through a req/ack/done handshake. Refreshes may be
// postponed up to MAX_REF_PENDING while a user program runs; at that limit
// the request becomes urgent and is issued regardless.
module maint_scheduler
    import maint_sched_pkg::*;
#(
    parameter int REF_INTERVAL    = 7800,
    parameter int ZQ_INTERVAL     = 128000,
    parameter int RD_INTERVAL     = 1000000,
    parameter int MAX_REF_PENDING = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 init_calib_complete,
    input  logic                 aref_en,
    input  logic                 aref_en_valid,
    input  logic                 program_active,
    output logic                 maint_req,
    input  logic                 maint_ack,
    output logic [1:0]           maint_type,
    input  logic                 maint_done,
    output logic [PENDING_W-1:0] ref_pending,
    output logic                 urgent,
    output logic                 overflow_err
);

    localparam logic [PENDING_W-1:0] REF_MAX = PENDING_W'(MAX_REF_PENDING);

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic [1:0]           type_next;
    logic                 ref_en;
    logic                 aref_valid_d;
    logic                 aref_val_d;
    logic                 ref_wrap;
    logic                 zq_wrap;
    logic                 rd_wrap;
    logic                 zq_pending;
    logic                 rd_pending;
    logic                 ref_clear;
    logic                 retire;
    logic                 ref_retire;
    logic                 zq_retire;
    logic                 rd_retire;
    logic                 ref_lost;
    logic [PENDING_W-1:0] ref_next;

    // Disabling auto-refresh wipes the owed count and restarts its timer;
    // losing calibration does the same for everything.
    assign ref_clear  = ~init_calib_complete | (aref_valid_d & ~aref_val_d);
    assign retire     = (state == ST_WAIT_DONE) & maint_done;
    assign ref_retire = retire & (maint_type == TYPE_REF);
    assign zq_retire  = retire & (maint_type == TYPE_ZQ);
    assign rd_retire  = retire & (maint_type == TYPE_RD);

    maint_interval_timer #(.INTERVAL(REF_INTERVAL)) u_ref_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (init_calib_complete & ref_en),
        .clr  (ref_clear),
        .wrap (ref_wrap)
    );

    maint_interval_timer #(.INTERVAL(ZQ_INTERVAL)) u_zq_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (init_calib_complete),
        .clr  (~init_calib_complete),
        .wrap (zq_wrap)
    );

    maint_interval_timer #(.INTERVAL(RD_INTERVAL)) u_rd_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (init_calib_complete),
        .clr  (~init_calib_complete),
        .wrap (rd_wrap)
    );

    // Auto-refresh enable: the strobe and value are staged one cycle, then loaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aref_valid_d <= 1'b0;
            aref_val_d   <= 1'b0;
            ref_en       <= 1'b1;
        end else begin
            aref_valid_d <= aref_en_valid;
            aref_val_d   <= aref_en;
            if (aref_valid_d) begin
                ref_en <= aref_val_d;
            end else begin
                ref_en <= ref_en;
            end
        end
    end

    // Next owed-refresh count: a wrap and a retire in the same cycle cancel out
    always_comb begin
        ref_next = ref_pending;
        ref_lost = 1'b0;
        if (ref_clear) begin
            ref_next = '0;
        end else if (ref_wrap && !ref_retire) begin
            if (ref_pending == REF_MAX) begin
                ref_lost = 1'b1;
            end else begin
                ref_next = ref_pending + PENDING_W'(1);
            end
        end else if (ref_retire && !ref_wrap && (ref_pending != '0)) begin
            ref_next = ref_pending - PENDING_W'(1);
        end else begin
            ref_next = ref_pending;
        end
    end

    // Owed-work bookkeeping; a flag set wins over a same-cycle retire
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_pending  <= '0;
            urgent       <= 1'b0;
            overflow_err <= 1'b0;
            zq_pending   <= 1'b0;
            rd_pending   <= 1'b0;
        end else begin
            ref_pending  <= ref_next;
            urgent       <= (ref_next == REF_MAX);
            overflow_err <= overflow_err | ref_lost;
            if (!init_calib_complete) begin
                zq_pending <= 1'b0;
                rd_pending <= 1'b0;
            end else begin
                zq_pending <= zq_wrap | (zq_pending & ~zq_retire);
                rd_pending <= rd_wrap | (rd_pending & ~rd_retire);
            end
        end
    end

    // Request selection and handshake sequencing
    always_comb begin
        state_next = state;
        type_next  = maint_type;
        case (state)
            ST_IDLE: begin
                if (!init_calib_complete) begin
                    state_next = ST_IDLE;
                end else if (urgent) begin
                    state_next = ST_REQ;
                    type_next  = TYPE_REF;
                end else if (program_active) begin
                    state_next = ST_IDLE;
                end else if (ref_pending != '0) begin
                    state_next = ST_REQ;
                    type_next  = TYPE_REF;
                end else if (zq_pending) begin
                    state_next = ST_REQ;
                    type_next  = TYPE_ZQ;
                end else if (rd_pending) begin
                    state_next = ST_REQ;
                    type_next  = TYPE_RD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (!init_calib_complete) begin
                    state_next = ST_IDLE;
                end else if (maint_ack) begin
                    state_next = ST_WAIT_DONE;
                end else begin
                    state_next = ST_REQ;
                end
            end
            ST_WAIT_DONE: begin
                if (maint_done) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_WAIT_DONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                type_next  = TYPE_REF;
            end
        endcase
    end

    // FSM state and registered request outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            maint_req  <= 1'b0;
            maint_type <= TYPE_REF;
        end else begin
            state      <= state_next;
            maint_req  <= (state_next == ST_REQ);
            maint_type <= type_next;
        end
    end

endmodule

// File: tb/tb_maint_scheduler.sv
// Directed bench for maint_scheduler with short intervals (16/64/128, limit 4).
// The stimulus process queues the request types it expects and value
// checks it captures; a monitor process pops and compares them. A frontend
// model answers requests with ack/done as enabled by the stimulus.
module tb_maint_scheduler;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_calib_complete;
    logic       aref_en;
    logic       aref_en_valid;
    logic       program_active;
    logic       maint_req;
    logic       maint_ack;
    logic [1:0] maint_type;
    logic       maint_done;
    logic [3:0] ref_pending;
    logic       urgent;
    logic       overflow_err;

    logic       ack_enable;
    logic       done_enable;
    int         tnow;
    int         vectors     = 0;
    int         miscompares = 0;
    logic [1:0] exp_q[$];
    chk_t       chk_q[$];

    maint_scheduler #(
        .REF_INTERVAL   (16),
        .ZQ_INTERVAL    (64),
        .RD_INTERVAL    (128),
        .MAX_REF_PENDING(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .init_calib_complete(init_calib_complete),
        .aref_en            (aref_en),
        .aref_en_valid      (aref_en_valid),
        .program_active     (program_active),
        .maint_req          (maint_req),
        .maint_ack          (maint_ack),
        .maint_type         (maint_type),
        .maint_done         (maint_done),
        .ref_pending        (ref_pending),
        .urgent             (urgent),
        .overflow_err       (overflow_err)
    );

    always #5 clk = ~clk;

    // Advance to the falling edge after rising edge number t (counted from calib)
    task automatic goto(input int t);
        while (tnow < t) begin
            @(negedge clk);
            tnow = tnow + 1;
        end
    endtask

    task automatic expect_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_types(input string seq);
        for (int i = 0; i < seq.len(); i++) begin
            if (seq[i] == "R")      exp_q.push_back(2'd0);
            else if (seq[i] == "Z") exp_q.push_back(2'd1);
            else                    exp_q.push_back(2'd2);
        end
    endtask

    // Frontend model: ack a presented request, then pulse done when allowed
    initial begin : frontend
        logic owe;
        owe        = 1'b0;
        maint_ack  = 1'b0;
        maint_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            maint_done = 1'b0;
            if (rst) begin
                maint_ack = 1'b0;
                owe       = 1'b0;
            end else if (maint_ack) begin
                maint_ack = 1'b0;
                if (done_enable) maint_done = 1'b1;
                else             owe = 1'b1;
            end else if (owe && done_enable) begin
                maint_done = 1'b1;
                owe        = 1'b0;
            end else if (maint_req && ack_enable) begin
                maint_ack = 1'b1;
            end
        end
    end

    // Monitor: compare each new request and every queued value check
    initial begin : monitor
        logic       prev_req;
        logic [1:0] e;
        chk_t       c;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (maint_req && !prev_req) begin
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL unexpected_request at t=%0d: got type %0d, expected none", tnow, maint_type);
                end else begin
                    e = exp_q.pop_front();
                    if (maint_type !== e) begin
                        miscompares = miscompares + 1;
                        $display("FAIL req_type at t=%0d: got %0d, expected %0d", tnow, maint_type, e);
                    end
                end
            end
            prev_req = maint_req;
            while (chk_q.size() != 0) begin
                c = chk_q.pop_front();
                vectors = vectors + 1;
                if (c.act !== c.exp) begin
                    miscompares = miscompares + 1;
                    $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
                end
            end
        end
    end

    initial begin : stimulus
        int mx;
        rst = 1'b1; init_calib_complete = 1'b0; aref_en = 1'b1; aref_en_valid = 1'b0;
        program_active = 1'b0; ack_enable = 1'b1; done_enable = 1'b1; tnow = 0;
        repeat (2) @(negedge clk);
        expect_val("rst_req",      32'(maint_req),    32'd0);
        expect_val("rst_type",     32'(maint_type),   32'd0);
        expect_val("rst_pending",  32'(ref_pending),  32'd0);
        expect_val("rst_urgent",   32'(urgent),       32'd0);
        expect_val("rst_overflow", 32'(overflow_err), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        expect_val("nocalib_pending", 32'(ref_pending), 32'd0);

        // Steady service: REF every 16 cycles, ZQ/RD after it
        init_calib_complete = 1'b1;
        push_types("RRRRZRRRRZD");
        goto(16);
        expect_val("first_wrap_pending", 32'(ref_pending), 32'd1);
        expect_val("req_not_yet",        32'(maint_req),   32'd0);
        goto(17);
        expect_val("req_latency", 32'(maint_req), 32'd1);
        mx = 1;
        while (tnow < 140) begin
            goto(tnow + 1);
            if (int'(ref_pending) > mx) mx = int'(ref_pending);
        end
        expect_val("p1_max_pending", 32'(mx), 32'd1);

        // Deferral while a program runs; urgent REF still goes out
        program_active = 1'b1;
        push_types("RRRRRRZRRZD");
        goto(192);
        expect_val("sat_pending", 32'(ref_pending), 32'd4);
        expect_val("sat_urgent",  32'(urgent),      32'd1);
        goto(196);
        expect_val("urgent_served_pending", 32'(ref_pending), 32'd3);
        expect_val("urgent_served_urgent",  32'(urgent),      32'd0);
        goto(220);
        expect_val("deferred_pending", 32'(ref_pending), 32'd3);
        program_active = 1'b0;
        goto(270);

        // Ack withheld: saturation, overflow, request held as REF
        ack_enable = 1'b0;
        push_types("RRRRZRZD");
        goto(274);
        expect_val("held_req",  32'(maint_req),  32'd1);
        expect_val("held_type", 32'(maint_type), 32'd0);
        goto(330);
        expect_val("held_pending",  32'(ref_pending),  32'd4);
        expect_val("pre_overflow",  32'(overflow_err), 32'd0);
        goto(340);
        expect_val("overflow_set",      32'(overflow_err), 32'd1);
        expect_val("overflow_pending",  32'(ref_pending),  32'd4);
        expect_val("overflow_req",      32'(maint_req),    32'd1);
        expect_val("overflow_type",     32'(maint_type),   32'd0);
        goto(370);
        ack_enable = 1'b1;
        goto(395);
        expect_val("drained_pending", 32'(ref_pending),  32'd0);
        expect_val("overflow_sticky", 32'(overflow_err), 32'd1);

        // Auto-refresh disabled with three refreshes owed
        program_active = 1'b1;
        goto(440);
        expect_val("pre_disable_pending", 32'(ref_pending), 32'd3);
        aref_en = 1'b0; aref_en_valid = 1'b1;
        goto(441);
        aref_en_valid = 1'b0; aref_en = 1'b1;
        goto(442);
        expect_val("disable_clears", 32'(ref_pending), 32'd0);
        goto(444);
        program_active = 1'b0;
        push_types("ZZD");
        goto(540);
        expect_val("disabled_no_ref", 32'(ref_pending), 32'd0);

        // Re-enable, then drop calibration while a request is presented
        ack_enable = 1'b0; aref_en = 1'b1; aref_en_valid = 1'b1;
        push_types("R");
        goto(541);
        aref_en_valid = 1'b0;
        goto(565);
        expect_val("pre_drop_req",     32'(maint_req),   32'd1);
        expect_val("pre_drop_pending", 32'(ref_pending), 32'd1);
        init_calib_complete = 1'b0;
        goto(566);
        expect_val("drop_req",     32'(maint_req),   32'd0);
        expect_val("drop_pending", 32'(ref_pending), 32'd0);
        expect_val("drop_urgent",  32'(urgent),      32'd0);

        // Reset while waiting for done
        goto(570);
        init_calib_complete = 1'b1; ack_enable = 1'b1; done_enable = 1'b0;
        push_types("R");
        goto(592);
        expect_val("wait_req",     32'(maint_req),   32'd0);
        expect_val("wait_pending", 32'(ref_pending), 32'd1);
        rst = 1'b1;
        goto(593);
        expect_val("mid_rst_req",      32'(maint_req),    32'd0);
        expect_val("mid_rst_type",     32'(maint_type),   32'd0);
        expect_val("mid_rst_pending",  32'(ref_pending),  32'd0);
        expect_val("mid_rst_urgent",   32'(urgent),       32'd0);
        expect_val("mid_rst_overflow", 32'(overflow_err), 32'd0);
        rst = 1'b0; done_enable = 1'b1;
        push_types("R");
        goto(615);
        expect_val("post_rst_pending", 32'(ref_pending), 32'd0);
        expect_val("post_rst_req",     32'(maint_req),   32'd0);
        expect_val("requests_left", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
